// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: runtime-configurable UART receiver (5-8 data bits, optional
// even/odd parity, 1 or 2 stop bits) feeding a first-word-fall-through FIFO
// of characters with per-character parity/frame error flags.
// Optional build macro: UART_RX_MAJORITY_EN -- when defined, every bit sample
// is the 2-of-3 majority of the last three cycles before the bit-centre tick.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int PERIOD_W   = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [PERIOD_W-1:0]           period,
    input  logic [1:0]                    cfg_bits,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_stop2,
    input  logic                          rxd,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [7:0]                    rd_data,
    output logic                          rd_parity_err,
    output logic                          rd_frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          overrun_clear
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam int WORD_W = 10;

    localparam logic [PERIOD_W-1:0] CNT_ZERO  = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] CNT_ONE   = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]       PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]       CNT_W_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]       DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_HUNT   = 3'd5
    } state_t;

    // XOR-reduction of the received data byte (unused upper bits are zero).
    function automatic logic xor8(input logic [7:0] v);
        return ^v;
    endfunction

    // ------------------------------------------------------------------
    // Line synchroniser and frame-configuration latch
    // ------------------------------------------------------------------
    logic                rxd_meta_r;
    logic                rxd_sync_r;
    logic [PERIOD_W-1:0] period_l_r;
    logic [1:0]          bits_l_r;
    logic                par_en_l_r;
    logic                par_odd_l_r;
    logic                stop2_l_r;

    // Two-flop synchroniser; resets to the idle-high level so reset never
    // looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM and datapath
    // ------------------------------------------------------------------
    state_t              state_r;
    state_t              state_next_s;
    logic [PERIOD_W-1:0] cnt_r;
    logic [2:0]          idx_r;
    logic [7:0]          buf_r;
    logic                perr_r;
    logic                ferr_r;
    logic                stop_second_r;

    logic                counting_s;
    logic                tick_s;
    logic                sample_s;
    logic [2:0]          last_idx_s;
    logic                perr_calc_s;
    logic                ferr_final_s;
    logic                start_frame_s;
    logic                data_begin_s;
    logic                data_bit_s;
    logic                parity_bit_s;
    logic                stop_first_s;
    logic                push_s;
    logic [WORD_W-1:0]   push_word_s;

    assign counting_s   = (state_r != ST_IDLE) && (state_r != ST_HUNT);
    assign tick_s       = counting_s && (cnt_r == (period_l_r - CNT_ONE));
    assign last_idx_s   = {1'b0, bits_l_r} + 3'd4;
    assign perr_calc_s  = ((xor8(buf_r) ^ sample_s) != par_odd_l_r);
    assign ferr_final_s = ferr_r | ~sample_s;
    assign push_word_s  = {perr_r, ferr_final_s, buf_r};

`ifdef UART_RX_MAJORITY_EN
    localparam logic [PERIOD_W-1:0] CNT_TWO   = {{(PERIOD_W-2){1'b0}}, 2'b10};
    localparam logic [PERIOD_W-1:0] CNT_THREE = {{(PERIOD_W-2){1'b0}}, 2'b11};

    logic maj_a_r;
    logic maj_b_r;

    // 2-of-3 vote used to reject a single-cycle glitch at the bit centre.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Capture the two early samples of each bit; the third is the tick cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            maj_a_r <= 1'b1;
            maj_b_r <= 1'b1;
        end else if (start_frame_s) begin
            maj_a_r <= 1'b0;
            maj_b_r <= 1'b0;
        end else if (counting_s && (cnt_r == (period_l_r - CNT_THREE))) begin
            maj_a_r <= rxd_sync_r;
        end else if (counting_s && (cnt_r == (period_l_r - CNT_TWO))) begin
            maj_b_r <= rxd_sync_r;
        end else begin
            maj_a_r <= maj_a_r;
            maj_b_r <= maj_b_r;
        end
    end

    assign sample_s = maj3(maj_a_r, maj_b_r, rxd_sync_r);
`else
    assign sample_s = rxd_sync_r;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and per-tick datapath strobes.
    always_comb begin
        state_next_s  = state_r;
        start_frame_s = 1'b0;
        data_begin_s  = 1'b0;
        data_bit_s    = 1'b0;
        parity_bit_s  = 1'b0;
        stop_first_s  = 1'b0;
        push_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rxd_sync_r) begin
                    state_next_s  = ST_START;
                    start_frame_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (sample_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_DATA;
                        data_begin_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    data_bit_s = 1'b1;
                    if (idx_r == last_idx_s) begin
                        state_next_s = par_en_l_r ? ST_PARITY : ST_STOP;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    parity_bit_s = 1'b1;
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (stop2_l_r && !stop_second_r) begin
                        stop_first_s = 1'b1;
                        state_next_s = ST_STOP;
                    end else begin
                        push_s       = 1'b1;
                        state_next_s = ferr_final_s ? ST_HUNT : ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_HUNT: begin
                if (rxd_sync_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HUNT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Baud counter: preloaded to half a period so ticks land at bit centres.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_r <= CNT_ZERO;
        end else if (start_frame_s) begin
            cnt_r <= period >> 1;
        end else if (!counting_s) begin
            cnt_r <= cnt_r;
        end else if (tick_s) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Latch the baud period and frame format at the start edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            period_l_r  <= CNT_ZERO;
            bits_l_r    <= 2'd0;
            par_en_l_r  <= 1'b0;
            par_odd_l_r <= 1'b0;
            stop2_l_r   <= 1'b0;
        end else if (start_frame_s) begin
            period_l_r  <= period;
            bits_l_r    <= cfg_bits;
            par_en_l_r  <= cfg_parity_en;
            par_odd_l_r <= cfg_parity_odd;
            stop2_l_r   <= cfg_stop2;
        end else begin
            period_l_r  <= period_l_r;
            bits_l_r    <= bits_l_r;
            par_en_l_r  <= par_en_l_r;
            par_odd_l_r <= par_odd_l_r;
            stop2_l_r   <= stop2_l_r;
        end
    end

    // Character assembly: data shift-in, parity check, stop-bit error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx_r         <= 3'd0;
            buf_r         <= 8'd0;
            perr_r        <= 1'b0;
            ferr_r        <= 1'b0;
            stop_second_r <= 1'b0;
        end else if (data_begin_s) begin
            idx_r         <= 3'd0;
            buf_r         <= 8'd0;
            perr_r        <= 1'b0;
            ferr_r        <= 1'b0;
            stop_second_r <= 1'b0;
        end else if (data_bit_s) begin
            buf_r[idx_r]  <= sample_s;
            idx_r         <= idx_r + 3'd1;
        end else if (parity_bit_s) begin
            perr_r        <= perr_calc_s;
        end else if (stop_first_s) begin
            ferr_r        <= ferr_final_s;
            stop_second_r <= 1'b1;
        end else begin
            idx_r         <= idx_r;
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              rd_valid_r;
    logic [WORD_W-1:0] head_r;
    logic              overrun_r;

    logic              full_s;
    logic              pop_s;
    logic              push_ok_s;
    logic              ovf_s;
    logic [CW-1:0]     count_next_s;
    logic [AW-1:0]     rd_ptr_next_s;
    logic [WORD_W-1:0] head_next_s;

    assign full_s    = (count_r == DEPTH_C);
    assign pop_s     = rd_en && rd_valid_r;
    assign push_ok_s = push_s && (!full_s || pop_s);
    assign ovf_s     = push_s && full_s && !pop_s;

    // Next occupancy, read pointer and head word, so the read outputs
    // can be registered while still falling through on the first push.
    always_comb begin
        count_next_s  = count_r;
        rd_ptr_next_s = rd_ptr_r;
        head_next_s   = {WORD_W{1'b0}};
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W_ONE;
            2'b01:   count_next_s = count_r - CNT_W_ONE;
            default: count_next_s = count_r;
        endcase
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = {WORD_W{1'b0}};
        end else if (push_ok_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = push_word_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage, pointers and registered read-side outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {WORD_W{1'b0}};
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            rd_valid_r <= 1'b0;
            head_r     <= {WORD_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_word_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            rd_ptr_r   <= rd_ptr_next_s;
            count_r    <= count_next_s;
            rd_valid_r <= (count_next_s != {CW{1'b0}});
            head_r     <= head_next_s;
        end
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            overrun_r <= 1'b0;
        end else if (ovf_s) begin
            overrun_r <= 1'b1;
        end else if (overrun_clear) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign rd_valid      = rd_valid_r;
    assign rd_data       = head_r[7:0];
    assign rd_frame_err  = head_r[8];
    assign rd_parity_err = head_r[9];
    assign fifo_count    = count_r;
    assign overrun       = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a table of single-character frames
// plus hand-written sequences for latency, break/hunt, back-to-back frames,
// FIFO overrun, false start, mid-frame reset and (with
// UART_RX_MAJORITY_EN) glitch rejection.
module tb_uart_rx_fifo;

    localparam int DEPTH = 4;
    localparam int P     = 16;

    logic        clk;
    logic        rstn;
    logic [15:0] period;
    logic [1:0]  cfg_bits;
    logic        cfg_parity_en;
    logic        cfg_parity_odd;
    logic        cfg_stop2;
    logic        rxd;
    logic        rd_en;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_parity_err;
    logic        rd_frame_err;
    logic [2:0]  fifo_count;
    logic        overrun;
    logic        overrun_clear;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .PERIOD_W(16)) dut (
        .clk(clk), .rstn(rstn), .period(period), .cfg_bits(cfg_bits),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2(cfg_stop2), .rxd(rxd), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_parity_err(rd_parity_err),
        .rd_frame_err(rd_frame_err), .fifo_count(fifo_count),
        .overrun(overrun), .overrun_clear(overrun_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] bits;
        bit         pe;
        bit         po;
        bit         s2;
        bit         flip_par;
        bit         stop_low;
        logic [7:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Hold the line at v for one bit time; optional inverted cycle at offset glitch_at.
    task automatic drive_bit(input logic v, input int glitch_at);
        for (int c = 0; c < P; c++) begin
            @(posedge clk);
            #1;
            rxd = (c == glitch_at) ? ~v : v;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] bits, input bit pe,
                              input bit po, input bit s2, input bit flip, input bit stop_low,
                              input int glitch_bit);
        int         nb;
        logic [7:0] mask;
        logic       pbit;
        nb   = int'(bits) + 5;
        mask = 8'hFF >> (8 - nb);
        cfg_bits       = bits;
        cfg_parity_en  = pe;
        cfg_parity_odd = po;
        cfg_stop2      = s2;
        drive_bit(1'b0, -1);
        for (int i = 0; i < nb; i++) begin
            drive_bit(d[i], (i == glitch_bit) ? 8 : -1);
        end
        if (pe) begin
            pbit = (^(d & mask)) ^ po ^ flip;
            drive_bit(pbit, -1);
        end
        if (stop_low) begin
            drive_bit(1'b0, -1);
            drive_bit(1'b0, -1);
            drive_bit(1'b0, -1);
            drive_bit(1'b1, -1);
        end else begin
            drive_bit(1'b1, -1);
            if (s2) drive_bit(1'b1, -1);
        end
    endtask

    task automatic pop();
        @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_head(input string name, input logic [7:0] d, input bit pe, input bit fe);
        check({name, ".valid"}, {15'd0, rd_valid}, 16'd1);
        check({name, ".data"}, {8'd0, rd_data}, {8'd0, d});
        check({name, ".perr"}, {15'd0, rd_parity_err}, {15'd0, pe});
        check({name, ".ferr"}, {15'd0, rd_frame_err}, {15'd0, fe});
    endtask

    task automatic check_empty(input string name);
        check({name, ".valid"}, {15'd0, rd_valid}, 16'd0);
        check({name, ".data"}, {8'd0, rd_data}, 16'd0);
        check({name, ".count"}, {13'd0, fifo_count}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        //               data   bits  pe    po    s2    flip  stopL exp    perr  ferr
        vecs[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h41, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0};
        vecs[2] = '{8'h41, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h2A, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b0};
        vecs[6] = '{8'h15, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 1'b1};
        vecs[7] = '{8'h1F, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b1};

        rstn = 1'b0; period = 16'(P); cfg_bits = 2'd3; cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0; rxd = 1'b1; rd_en = 1'b0;
        overrun_clear = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_empty("reset");
        check("reset.perr", {15'd0, rd_parity_err}, 16'd0);
        check("reset.ferr", {15'd0, rd_frame_err}, 16'd0);
        check("reset.overrun", {15'd0, overrun}, 16'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (4) @(posedge clk);

        // 8N1 0xA5: latency from start edge to rd_valid.
        lat = -1;
        fork
            send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
            begin
                @(posedge clk);
                for (int k = 1; k <= 400; k++) begin
                    @(negedge clk);
                    if (rd_valid) begin
                        lat = k - 1;
                        break;
                    end
                end
            end
        join
        check("latency", 16'(lat), 16'd155);
        @(negedge clk);
        check_head("a5", 8'hA5, 1'b0, 1'b0);
        check("a5.count", {13'd0, fifo_count}, 16'd1);
        pop();
        check_empty("a5.pop");
        pop();
        check_empty("empty_pop");

        // Table of single frames.
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].data, vecs[v].bits, vecs[v].pe, vecs[v].po, vecs[v].s2,
                       vecs[v].flip_par, vecs[v].stop_low, -1);
            @(negedge clk);
            check_head($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr);
            check($sformatf("vec%0d.count", v), {13'd0, fifo_count}, 16'd1);
            pop();
            check_empty($sformatf("vec%0d.pop", v));
        end

        // Break: stop bit low, line held low, then a clean frame -> exactly two entries.
        cfg_bits = 2'd3;
        send_frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h7E, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        repeat (2 * P) @(posedge clk);
        @(negedge clk);
        check("brk.count", {13'd0, fifo_count}, 16'd2);
        check_head("brk0", 8'h3C, 1'b0, 1'b1);
        pop();
        check_head("brk1", 8'h7E, 1'b0, 1'b0);
        pop();
        check_empty("brk.pop");

        // 5O2 back-to-back.
        send_frame(8'h15, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'h0A, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        @(negedge clk);
        check("5o2.count", {13'd0, fifo_count}, 16'd2);
        check_head("5o2_0", 8'h15, 1'b0, 1'b0);
        pop();
        check_head("5o2_1", 8'h0A, 1'b0, 1'b0);
        pop();
        check_empty("5o2.pop");

        // Overrun with a 4-deep FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        end
        @(negedge clk);
        check("ovr.count", {13'd0, fifo_count}, 16'd4);
        check("ovr.flag", {15'd0, overrun}, 16'd1);
        for (int i = 1; i <= 4; i++) begin
            check_head($sformatf("ovr%0d", i), 8'(i), 1'b0, 1'b0);
            pop();
        end
        check_empty("ovr.pop");
        check("ovr.sticky", {15'd0, overrun}, 16'd1);
        @(posedge clk);
        #1 overrun_clear = 1'b1;
        @(posedge clk);
        #1 overrun_clear = 1'b0;
        @(negedge clk);
        check("ovr.clear", {15'd0, overrun}, 16'd0);

        // False start: 4-cycle low pulse, then a normal frame still decodes.
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (3 * P) @(posedge clk);
        @(negedge clk);
        check_empty("fstart");
        send_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        @(negedge clk);
        check_head("fstart.after", 8'h5A, 1'b0, 1'b0);
        check("fstart.count", {13'd0, fifo_count}, 16'd1);
        pop();

        // Reset in the middle of a frame discards it.
        cfg_bits = 2'd3;
        drive_bit(1'b0, -1);
        drive_bit(1'b1, -1);
        drive_bit(1'b0, -1);
        @(posedge clk);
        #1 begin rstn = 1'b0; rxd = 1'b1; end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (12 * P) @(posedge clk);
        @(negedge clk);
        check_empty("midreset");
        send_frame(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        @(negedge clk);
        check_head("midreset.after", 8'hC3, 1'b0, 1'b0);
        pop();

`ifdef UART_RX_MAJORITY_EN
        // One-cycle high glitch at the centre of data bit 3 is voted out.
        send_frame(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        @(negedge clk);
        check_head("glitch", 8'h00, 1'b0, 1'b0);
        pop();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. Frame format is runtime-configurable: 5–8 data bits, optional even/odd parity, 1 or 2 stop bits. Received characters and their per-character error flags go into an internal first-word-fall-through FIFO. Sits behind the UART MMIO bridge, which pops characters and reads the status flags.

Parameters:
FIFO_DEPTH, 8, number of FIFO entries; power of 2, minimum 2
PERIOD_W, 16, width of the baud period input

Ports:
clk  input  1  system clock
rstn  input  1  reset, synchronous, active-low
period  input  PERIOD_W  clock cycles per bit; must be >= 4
cfg_bits  input  2  data bits: 0=5, 1=6, 2=7, 3=8
cfg_parity_en  input  1  1 = parity bit present
cfg_parity_odd  input  1  1 = odd parity, 0 = even parity
cfg_stop2  input  1  1 = two stop bits
rxd  input  1  serial line, asynchronous, idle high
rd_en  input  1  pop FIFO head
rd_valid  output  1  FIFO non-empty
rd_data  output  8  head character, right-aligned, unused upper bits 0
rd_parity_err  output  1  head character had a parity error
rd_frame_err  output  1  head character had a stop-bit error
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied entries
overrun  output  1  sticky: a character was dropped because the FIFO was full
overrun_clear  input  1  clears overrun

Behaviour:
- Reset: state IDLE, FIFO empty, fifo_count 0, rd_valid 0, rd_data 0, both err outputs 0, overrun 0. Reset mid-frame discards the partial frame.
- rxd passes through a 2-flop synchroniser (rxd_s); all decisions use rxd_s.
- Baud counter cnt (PERIOD_W bits):
  - Increments every cycle outside IDLE/HUNT.
  - tick = (cnt == period_l-1); on tick, cnt <= 0.
  - On IDLE->START, cnt <= period_l>>1, so samples land at bit centres.
- Frame latch: period and all cfg_* are latched (period_l, cfg_l) on IDLE->START. Changes mid-frame do not affect the current frame.
- States:
  - IDLE: rxd_s==0 -> START.
  - START: on tick, sample 1 -> IDLE (false start, nothing pushed); sample 0 -> DATA, idx=0, buffer=0.
  - DATA: on tick, buffer[idx] <= sample. After bit number (cfg_bits+5)-1 -> PARITY if parity enabled, else STOP; otherwise idx+1.
  - PARITY: on tick, perr = (^data_bits ^ sample) != cfg_parity_odd. Then -> STOP.
  - STOP: on tick, a sample of 0 sets ferr. With cfg_stop2, the first stop tick stays in STOP and the second stop tick is the final one; ferr is the OR of both samples.
  - On the final stop tick: push {perr, ferr, buffer}. Next state is IDLE if ferr==0, else HUNT.
  - HUNT: wait for rxd_s==1, then -> IDLE. A held-low break line produces only one errored character.
- FIFO:
  - Push takes effect at the final stop tick; rd_valid/rd_data update the next cycle.
  - Pop occurs on rd_en && rd_valid. rd_en while empty is ignored.
  - Push while full and no pop: character dropped, overrun <= 1, FIFO unchanged.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overrun.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - When empty, rd_data and both err outputs read 0.
- overrun_clear clears overrun; if a new overrun occurs in the same cycle, set wins.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each sample (start, data, parity, stop) is the 2-of-3 majority of rxd_s on the cycles where cnt == period_l-3, period_l-2 and period_l-1. The result is used at tick. A single-cycle glitch at the bit centre is rejected.
- Undefined: the sample is rxd_s at tick only. The three-sample registers are not built.

Test Plan:
- period=16, 8N1, send 0xA5 -> rd_valid rises ~152 cycles after the start edge; rd_data=0xA5, both err=0, fifo_count=1. rd_en pulse -> rd_valid=0, rd_data=0.
- 7E1, send 0x41 with the parity bit inverted -> rd_data=0x41, rd_parity_err=1, rd_frame_err=0. Repeat with correct parity -> both err=0.
- 8N1, 0x3C with stop bit 0 and the line held low for 3 bit times, then 0x7E -> first entry 0x3C with frame_err=1; exactly two entries; second entry 0x7E clean.
- 5O2, send 0x15 then 0x0A back-to-back -> rd_data 0x15 then 0x0A, upper bits 0, no errors.
- FIFO_DEPTH=4, send 0x01..0x05 without reading -> fifo_count=4, overrun=1. Reads return 0x01..0x04 in order. overrun_clear -> overrun=0.
- rxd low pulse of 4 cycles (period=16) -> no push, state back in IDLE. With UART_RX_MAJORITY_EN, a 1-cycle high glitch at the centre of a 0 data bit -> bit still received as 0.
